// File: rtl/ascon_pkg.sv
// Shared constants and FSM encoding for the ASCON-128 encryption sequencer.
package ascon_pkg;

  localparam logic [63:0] IV       = 64'h80400c0600000000;
  localparam logic [4:0]  ROUNDS_A = 5'd12;
  localparam logic [4:0]  ROUNDS_B = 5'd6;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT_W = 3'd1,
    AD_RD  = 3'd2,
    AD_W   = 3'd3,
    DSEP   = 3'd4,
    PT_RD  = 3'd5,
    PT_W   = 3'd6,
    FIN_W  = 3'd7
  } state_t;

  // Replace the rate word x0 of a 320-bit state.
  function automatic logic [319:0] set_x0(input logic [319:0] s, input logic [63:0] x0);
    return {x0, s[255:0]};
  endfunction

endpackage

// File: rtl/ascon_aead_ctrl.sv
// ASCON-128 encryption sequencer: builds the sponge state, drives an external
// permutation core and emits ciphertext blocks followed by the tag.
module ascon_aead_ctrl
  import ascon_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] nonce,
  input  logic         has_ad,
  input  logic [63:0]  din,
  input  logic         din_last,
  input  logic         din_valid,
  output logic         din_ready,
  output logic [63:0]  ct,
  output logic         ct_valid,
  output logic [127:0] tag,
  output logic         tag_valid,
  output logic         busy,
  output logic [319:0] perm_S,
  output logic [4:0]   perm_round,
  output logic         perm_start,
  input  logic [319:0] perm_S_out,
  input  logic         perm_fin
);

  state_t         state_r, state_nx;
  logic [319:0]   s_r, s_nx;
  logic [127:0]   key_r, key_nx;
  logic           has_ad_r, has_ad_nx;
  logic           last_r, last_nx;
  logic [63:0]    ct_r, ct_nx;
  logic           ct_valid_r, ct_valid_nx;
  logic [127:0]   tag_r, tag_nx;
  logic           tag_valid_r, tag_valid_nx;
  logic           busy_r, busy_nx;
  logic           din_ready_r, din_ready_nx;
  logic           perm_start_r, perm_start_nx;
  logic [4:0]     perm_round_r, perm_round_nx;
  logic [63:0]    c_s;

  // Next-state, datapath and output decode.
  always_comb begin
    state_nx      = state_r;
    s_nx          = s_r;
    key_nx        = key_r;
    has_ad_nx     = has_ad_r;
    last_nx       = last_r;
    ct_nx         = ct_r;
    ct_valid_nx   = 1'b0;
    tag_nx        = tag_r;
    tag_valid_nx  = 1'b0;
    perm_start_nx = 1'b0;
    perm_round_nx = perm_round_r;
    c_s           = s_r[319:256] ^ din;
    case (state_r)
      IDLE: begin
        if (start) begin
          s_nx          = {IV, key, nonce};
          key_nx        = key;
          has_ad_nx     = has_ad;
          tag_nx        = 128'd0;
          perm_start_nx = 1'b1;
          perm_round_nx = ROUNDS_A;
          state_nx      = INIT_W;
        end else begin
          state_nx = IDLE;
        end
      end
      INIT_W: begin
        if (perm_fin) begin
          s_nx     = perm_S_out ^ {192'd0, key_r};
          state_nx = has_ad_r ? AD_RD : DSEP;
        end else begin
          state_nx = INIT_W;
        end
      end
      AD_RD: begin
        if (din_valid) begin
          s_nx          = set_x0(s_r, c_s);
          last_nx       = din_last;
          perm_start_nx = 1'b1;
          perm_round_nx = ROUNDS_B;
          state_nx      = AD_W;
        end else begin
          state_nx = AD_RD;
        end
      end
      AD_W: begin
        if (perm_fin) begin
          s_nx     = perm_S_out;
          state_nx = last_r ? DSEP : AD_RD;
        end else begin
          state_nx = AD_W;
        end
      end
      DSEP: begin
        s_nx     = {s_r[319:1], ~s_r[0]};
        state_nx = PT_RD;
      end
      PT_RD: begin
        if (din_valid) begin
          ct_nx         = c_s;
          ct_valid_nx   = 1'b1;
          perm_start_nx = 1'b1;
          // Last block: key is folded into x1..x2 in the same step as x0 update.
          if (din_last) begin
            s_nx          = {c_s, s_r[255:128] ^ key_r, s_r[127:0]};
            perm_round_nx = ROUNDS_A;
            state_nx      = FIN_W;
          end else begin
            s_nx          = set_x0(s_r, c_s);
            perm_round_nx = ROUNDS_B;
            state_nx      = PT_W;
          end
        end else begin
          state_nx = PT_RD;
        end
      end
      PT_W: begin
        if (perm_fin) begin
          s_nx     = perm_S_out;
          state_nx = PT_RD;
        end else begin
          state_nx = PT_W;
        end
      end
      FIN_W: begin
        if (perm_fin) begin
          tag_nx       = perm_S_out[127:0] ^ key_r;
          tag_valid_nx = 1'b1;
          state_nx     = IDLE;
        end else begin
          state_nx = FIN_W;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
    busy_nx      = (state_nx != IDLE);
    din_ready_nx = (state_nx == AD_RD) || (state_nx == PT_RD);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      s_r          <= 320'd0;
      key_r        <= 128'd0;
      has_ad_r     <= 1'b0;
      last_r       <= 1'b0;
      ct_r         <= 64'd0;
      ct_valid_r   <= 1'b0;
      tag_r        <= 128'd0;
      tag_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
      din_ready_r  <= 1'b0;
      perm_start_r <= 1'b0;
      perm_round_r <= 5'd0;
    end else begin
      state_r      <= state_nx;
      s_r          <= s_nx;
      key_r        <= key_nx;
      has_ad_r     <= has_ad_nx;
      last_r       <= last_nx;
      ct_r         <= ct_nx;
      ct_valid_r   <= ct_valid_nx;
      tag_r        <= tag_nx;
      tag_valid_r  <= tag_valid_nx;
      busy_r       <= busy_nx;
      din_ready_r  <= din_ready_nx;
      perm_start_r <= perm_start_nx;
      perm_round_r <= perm_round_nx;
    end
  end

  assign din_ready  = din_ready_r;
  assign ct         = ct_r;
  assign ct_valid   = ct_valid_r;
  assign tag        = tag_r;
  assign tag_valid  = tag_valid_r;
  assign busy       = busy_r;
  assign perm_S     = s_r;
  assign perm_round = perm_round_r;
  assign perm_start = perm_start_r;

endmodule

// File: tb/tb_ascon_aead_ctrl.sv
// Scoreboard bench for ascon_aead_ctrl with a behavioural permutation core and
// an algorithm-level ASCON-128 reference model.
module tb_ascon_aead_ctrl;

  localparam logic [63:0] IV_C = 64'h80400c0600000000;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] key;
  logic [127:0] nonce;
  logic         has_ad;
  logic [63:0]  din;
  logic         din_last;
  logic         din_valid;
  logic         din_ready;
  logic [63:0]  ct;
  logic         ct_valid;
  logic [127:0] tag;
  logic         tag_valid;
  logic         busy;
  logic [319:0] perm_S;
  logic [4:0]   perm_round;
  logic         perm_start;
  logic [319:0] perm_S_out;
  logic         perm_fin;

  ascon_aead_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .key(key), .nonce(nonce), .has_ad(has_ad),
    .din(din), .din_last(din_last), .din_valid(din_valid), .din_ready(din_ready),
    .ct(ct), .ct_valid(ct_valid), .tag(tag), .tag_valid(tag_valid), .busy(busy),
    .perm_S(perm_S), .perm_round(perm_round), .perm_start(perm_start),
    .perm_S_out(perm_S_out), .perm_fin(perm_fin)
  );

  typedef struct {
    logic [4:0]   rnd;
    bit           chk;
    logic [319:0] s;
  } perm_exp_t;

  perm_exp_t    exp_perm_q[$];
  logic [63:0]  exp_ct_q[$];
  logic [127:0] exp_tag_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [63:0] ror(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // ASCON permutation p^nr as in the reference C implementation.
  function automatic logic [319:0] ascon_p(input logic [319:0] s, input int nr);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    logic [7:0]  rc;
    {x0, x1, x2, x3, x4} = s;
    for (int i = 12 - nr; i < 12; i++) begin
      rc = 8'(((15 - i) << 4) | i);
      x2 = x2 ^ {56'd0, rc};
      x0 ^= x4; x4 ^= x3; x2 ^= x1;
      t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
      x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
      x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
      x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
      x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
      x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
      x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
      x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
    end
    return {x0, x1, x2, x3, x4};
  endfunction

  // Permutation core stand-in: random latency, aborts on reset.
  initial begin
    logic [319:0] ps;
    logic [4:0]   pr;
    int           lat;
    bit           aborted, stable, rdy_low;
    perm_exp_t    e;
    perm_fin   = 1'b0;
    perm_S_out = 320'd0;
    forever begin
      @(posedge clk); #1;
      if (!rst && perm_start) begin
        ps = perm_S;
        pr = perm_round;
        if (exp_perm_q.size() == 0) begin
          chk("perm_unexpected", 320'(perm_start), 320'd0);
        end else begin
          e = exp_perm_q.pop_front();
          chk("perm_round", 320'(pr), 320'(e.rnd));
          if (e.chk) chk("perm_init_S", ps, e.s);
        end
        lat = int'($urandom_range(1, 4));
        aborted = 1'b0; stable = 1'b1; rdy_low = 1'b1;
        for (int i = 0; i < lat; i++) begin
          @(posedge clk); #1;
          if (rst) aborted = 1'b1;
          stable  = stable && (perm_S === ps);
          rdy_low = rdy_low && (din_ready === 1'b0);
        end
        if (!aborted) begin
          chk("wait_stable_noready", 320'({stable, rdy_low}), 320'd3);
          perm_S_out = ascon_p(ps, int'(pr));
          perm_fin = 1'b1;
          @(posedge clk); #1;
          perm_fin = 1'b0;
        end
      end
    end
  end

  // Output monitor: pops expectations whenever the DUT presents a result.
  always @(negedge clk) begin
    logic [63:0]  ect;
    logic [127:0] etag;
    if (ct_valid) begin
      if (exp_ct_q.size() == 0) chk("ct_unexpected", 320'(ct_valid), 320'd0);
      else begin
        ect = exp_ct_q.pop_front();
        chk("ct", 320'(ct), 320'(ect));
      end
    end
    if (tag_valid) begin
      if (exp_tag_q.size() == 0) chk("tag_unexpected", 320'(tag_valid), 320'd0);
      else begin
        etag = exp_tag_q.pop_front();
        chk("tag", 320'(tag), 320'(etag));
      end
      chk("busy_at_tag", 320'(busy), 320'd0);
    end
  end

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [127:0] r128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic wait_idle();
    int cnt = 0;
    while (busy === 1'b1 && cnt < 400) begin
      @(negedge clk);
      cnt++;
    end
    chk("idle_timeout", 320'(busy), 320'd0);
    @(posedge clk); #1;
  endtask

  // One message: reference expectations first, then drive the DUT.
  task automatic run_msg(input logic [127:0] k, input logic [127:0] n, input int nad,
                         input int npt, input bit hold, input bit abort_pt, input bit pad_only);
    logic [63:0]  blk[$];
    bit           lst[$];
    logic [319:0] s;
    logic [63:0]  c;
    perm_exp_t    e;
    int           cnt;
    for (int i = 0; i < nad; i++) begin blk.push_back(r64()); lst.push_back(i == nad - 1); end
    for (int i = 0; i < npt; i++) begin
      blk.push_back(pad_only ? 64'h8000000000000000 : r64());
      lst.push_back(i == npt - 1);
    end
    s = {IV_C, k, n};
    e.rnd = 5'd12; e.chk = 1'b1; e.s = s; exp_perm_q.push_back(e);
    s = ascon_p(s, 12) ^ {192'd0, k};
    e.chk = 1'b0; e.s = 320'd0;
    for (int i = 0; i < nad; i++) begin
      s[319:256] = s[319:256] ^ blk[i];
      e.rnd = 5'd6; exp_perm_q.push_back(e);
      s = ascon_p(s, 6);
    end
    s[0] = ~s[0];
    for (int i = 0; i < npt; i++) begin
      c = s[319:256] ^ blk[nad + i];
      exp_ct_q.push_back(c);
      s[319:256] = c;
      if (i < npt - 1) begin
        e.rnd = 5'd6; exp_perm_q.push_back(e);
        s = ascon_p(s, 6);
      end
    end
    s[255:128] = s[255:128] ^ k;
    e.rnd = 5'd12; exp_perm_q.push_back(e);
    s = ascon_p(s, 12);
    exp_tag_q.push_back(s[127:0] ^ k);

    wait_idle();
    start = 1'b1; key = k; nonce = n; has_ad = (nad > 0);
    @(posedge clk); #1;
    start = 1'b0; key = r128(); nonce = r128(); has_ad = 1'($urandom_range(0, 1));
    for (int j = 0; j < nad + npt; j++) begin
      din = blk[j]; din_last = lst[j]; din_valid = 1'b1;
      if (hold && j == 0) begin start = 1'b1; key = r128(); end
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
      end while (din_ready !== 1'b1 && cnt < 400);
      chk("ready_timeout", 320'(din_ready), 320'd1);
      @(posedge clk); #1;
      start = 1'b0;
      if (abort_pt && j == nad) begin
        #1 rst = 1'b1;
        #1;
        chk("rst_busy", 320'(busy), 320'd0);
        chk("rst_ct_valid", 320'(ct_valid), 320'd0);
        chk("rst_tag_valid", 320'(tag_valid), 320'd0);
        chk("rst_outs", 320'({din_ready, perm_start}), 320'd0);
        exp_ct_q.delete(); exp_tag_q.delete(); exp_perm_q.delete();
        din_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        return;
      end
      if (hold) begin
        din = r64(); din_last = 1'($urandom_range(0, 1));
      end else begin
        din_valid = 1'b0;
        repeat (int'($urandom_range(0, 2))) @(posedge clk);
        #1;
      end
    end
    wait_idle();
    din_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; key = 128'd0; nonce = 128'd0; has_ad = 1'b0;
    din = 64'd0; din_last = 1'b0; din_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_flags", 320'({busy, ct_valid, tag_valid, din_ready, perm_start}), 320'd0);
    chk("reset_perm_S", perm_S, 320'd0);
    chk("reset_data", 320'({ct, tag, perm_round}), 320'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    run_msg(128'd0, 128'd0, 0, 1, 1'b0, 1'b0, 1'b1);
    run_msg(128'h000102030405060708090a0b0c0d0e0f, 128'h000102030405060708090a0b0c0d0e0f,
            0, 1, 1'b0, 1'b0, 1'b1);
    chk("kat_tag", 320'(tag), 320'(128'he355159f292911f794cb1432a0103a8a));
    run_msg(r128(), r128(), 2, 3, 1'b0, 1'b0, 1'b0);
    run_msg(r128(), r128(), 1, 2, 1'b1, 1'b0, 1'b0);
    for (int m = 0; m < 6; m++) begin
      run_msg(r128(), r128(), int'($urandom_range(0, 3)), int'($urandom_range(1, 4)),
              1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end
    run_msg(r128(), r128(), 1, 3, 1'b0, 1'b1, 1'b0);
    run_msg(r128(), r128(), 2, 2, 1'b0, 1'b0, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    chk("ct_q_drained", 320'(exp_ct_q.size()), 320'd0);
    chk("tag_q_drained", 320'(exp_tag_q.size()), 320'd0);
    chk("perm_q_drained", 320'(exp_perm_q.size()), 320'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
